color_ratio_divider: RTL and testbench

COLOR_RATIO_DIVIDER -- requirements
Module: color_ratio_divider

---
 rtl/color_ratio_divider.sv | 137 +++++++++++++
 tb/tb_color_ratio_divider.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/color_ratio_divider.sv
// color_ratio_divider: per-channel floor(color_k * SCALE / clear) using a
// multi-channel restoring shift-subtract divider that shares one divisor.
// The result is saturated to WIDTH bits. A zero divisor skips the divide and
// returns all-ones with div_zero set.
module color_ratio_divider #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 3,
  parameter int SCALE    = 100
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CHANNELS*WIDTH-1:0]   color,
  input  logic [WIDTH-1:0]            clear,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CHANNELS*WIDTH-1:0]   res,
  output logic [CHANNELS-1:0]         sat,
  output logic                        div_zero
);

  localparam int QW = WIDTH + 8;
  localparam int CW = $clog2(QW + 1);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] clr;

  // quo starts as the scaled dividend; quotient bits shift in at the LSB
  // as dividend bits shift out at the MSB.
  logic [QW-1:0]   quo     [CHANNELS];
  logic [QW:0]     rem     [CHANNELS];
  logic [QW-1:0]   quo_nx  [CHANNELS];
  logic [QW:0]     rem_nx  [CHANNELS];
  logic [QW+1:0]   shf     [CHANNELS];
  logic [QW+1:0]   dif     [CHANNELS];
  logic [QW-1:0]   prod    [CHANNELS];
  logic [QW+1:0]   divisor;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign divisor   = {{(QW + 2 - WIDTH){1'b0}}, clr};

  // Scaled numerators and one restoring-division step for each channel
  always_comb begin
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      prod[k]   = QW'(color[k*WIDTH +: WIDTH]) * QW'(SCALE);
      shf[k]    = {rem[k], quo[k][QW-1]};
      dif[k]    = shf[k] - divisor;
      // The remainder MSB is always zero, so the borrow out of the
      // subtraction is exactly the "shifted < divisor" test.
      if (!dif[k][QW+1]) begin
        rem_nx[k] = dif[k][QW:0];
        quo_nx[k] = {quo[k][QW-2:0], 1'b1};
      end else begin
        rem_nx[k] = shf[k][QW:0];
        quo_nx[k] = {quo[k][QW-2:0], 1'b0};
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = (clear == '0) ? DONE : DIVIDE;
      DIVIDE:  if (cnt == CW'(1)) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, divider iteration and result write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      clr      <= '0;
      res      <= '0;
      sat      <= '0;
      div_zero <= 1'b0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        quo[k] <= '0;
        rem[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            clr <= clear;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
              quo[k] <= prod[k];
              rem[k] <= '0;
            end
            if (clear == '0) begin
              cnt      <= '0;
              res      <= '1;
              sat      <= '0;
              div_zero <= 1'b1;
            end else begin
              cnt <= CW'(QW);
            end
          end
        end
        DIVIDE: begin
          cnt <= cnt - CW'(1);
          for (int unsigned k = 0; k < CHANNELS; k++) begin
            quo[k] <= quo_nx[k];
            rem[k] <= rem_nx[k];
          end
          if (cnt == CW'(1)) begin
            div_zero <= 1'b0;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
              sat[k] <= |quo_nx[k][QW-1:WIDTH];
              res[k*WIDTH +: WIDTH] <= (|quo_nx[k][QW-1:WIDTH]) ? '1
                                                                : quo_nx[k][WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_color_ratio_divider.sv
// tb_color_ratio_divider: randomized and directed operand sets checked
// against an arithmetic reference model of the scaled ratio.
module tb_color_ratio_divider;

  localparam int W  = 16;
  localparam int C  = 3;
  localparam int S  = 100;
  localparam int QW = W + 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [C*W-1:0] color;
  logic [W-1:0]   clear;
  logic           out_valid;
  logic           out_ready;
  logic [C*W-1:0] res;
  logic [C-1:0]   sat;
  logic           div_zero;

  int n_chk  = 0;
  int n_fail = 0;
  logic [C*W-1:0] prev_res;

  color_ratio_divider #(.WIDTH(W), .CHANNELS(C), .SCALE(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .color(color), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .sat(sat), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the whole scaled ratio
  task automatic model(input logic [C*W-1:0] c, input logic [W-1:0] cl,
                       output logic [C*W-1:0] r, output logic [C-1:0] s,
                       output logic d);
    longint num, q;
    r = '0; s = '0; d = 1'b0;
    for (int k = 0; k < C; k++) begin
      num = longint'(c[k*W +: W]) * S;
      if (cl == 0) begin
        r[k*W +: W] = 16'hFFFF;
        d = 1'b1;
      end else begin
        q = num / longint'(cl);
        if (q > 65535) begin
          r[k*W +: W] = 16'hFFFF;
          s[k] = 1'b1;
        end else begin
          r[k*W +: W] = q[W-1:0];
        end
      end
    end
  endtask

  task automatic garbage(input logic iv);
    in_valid = iv;
    color    = {$urandom, $urandom};
    clear    = W'($urandom);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle
  task automatic run_op(input logic [C*W-1:0] c, input logic [W-1:0] cl, input int hold);
    logic [C*W-1:0] er;
    logic [C-1:0]   es;
    logic           ed;
    int lat;
    model(c, cl, er, es, ed);
    in_valid = 1'b1; color = c; clear = cl; out_ready = 1'b0;
    chk("idle_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk("busy_rdy", 64'(in_ready), 64'd0);
      chk("busy_res", 64'(res), 64'(prev_res));
      garbage(1'($urandom));
      out_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    out_ready = 1'b0;
    chk("latency", 64'(lat), (cl == 0) ? 64'd0 : 64'(QW));
    chk("res", 64'(res), 64'(er));
    chk("sat", 64'(sat), 64'(es));
    chk("div_zero", 64'(div_zero), 64'(ed));
    prev_res = er;
    for (int i = 0; i < hold; i++) begin
      garbage(1'b1);
      @(negedge clk);
      chk("hold_res", 64'(res), 64'(er));
      chk("hold_rdy", 64'(in_ready), 64'd0);
      chk("hold_vld", 64'(out_valid), 64'd1);
    end
    garbage(1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("exit_vld", 64'(out_valid), 64'd0);
    chk("exit_rdy", 64'(in_ready), 64'd1);
    chk("exit_res", 64'(res), 64'(er));
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [C*W-1:0] rc;
    logic [W-1:0]   rcl;
    int sel;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; color = '0; clear = '0;
    prev_res = '0;
    #1;
    chk("rst_res", 64'(res), 64'd0);
    chk("rst_sat", 64'(sat), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run_op({16'd0, 16'd250, 16'd500}, 16'd1000, 0);
    run_op({16'd1000, 16'd999, 16'd1}, 16'd1000, 1);
    run_op({16'd65535, 16'd655, 16'd656}, 16'd1, 0);
    run_op({16'h1234, 16'hABCD, 16'h0001}, 16'd0, 2);
    run_op({16'd300, 16'd200, 16'd100}, 16'd7, 5);

    // Asynchronous reset in the middle of a divide
    in_valid = 1'b1; color = {16'd40000, 16'd3, 16'd777}; clear = 16'd9;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_res", 64'(res), 64'd0);
    chk("mid_rst_vld", 64'(out_valid), 64'd0);
    chk("mid_rst_rdy", 64'(in_ready), 64'd1);
    chk("mid_rst_sat", 64'(sat), 64'd0);
    prev_res = '0;
    @(negedge clk);
    rst = 1'b0;
    run_op({16'd40000, 16'd3, 16'd777}, 16'd9, 0);

    for (int n = 0; n < 30; n++) begin
      rc = {$urandom, $urandom};
      for (int k = 0; k < C; k++)
        if ($urandom_range(0, 5) == 0) rc[k*W +: W] = '0;
      sel = $urandom_range(0, 7);
      if (sel == 0)      rcl = '0;
      else if (sel < 3)  rcl = W'($urandom_range(1, 16));
      else               rcl = W'($urandom);
      run_op(rc, rcl, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
